// File: rtl/axi_lite_pkg.sv
// Shared types and address decode for the AXI4-Lite MMIO responder.
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'b00,
    CH_DEVICE = 2'b01,
    CH_RESP   = 2'b10
  } ch_state_t;

  // Both channels run the same handshake FSM; these aliases name each use.
  typedef ch_state_t w_state_t;
  typedef ch_state_t r_state_t;

  // word_diff = {0,addr[31:2]} - {0,base[31:2]}; bit 30 is the borrow (addr below window).
  function automatic axi_resp_t decode_addr(input logic [30:0] word_diff,
                                            input logic [1:0]  addr_lsb,
                                            input logic [31:0] space);
    if (word_diff[30] || ({2'b00, word_diff[29:0]} >= space)) return DECERR;
    if (addr_lsb != 2'b00) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_channel_fsm.sv
// Request/response handshake shared by the write and read channels.
// Optional device watchdog is enabled by defining AXI_RESPONDER_TIMEOUT_EN.
//   state     | meaning
//   CH_IDLE   | waiting for the address (and data) to be captured
//   CH_DEVICE | device request asserted, waiting for done
//   CH_RESP   | response valid, waiting for the master's ready
module axi_lite_channel_fsm
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [1:0] dec_resp_i,
  input  logic       done_i,
  input  logic       error_i,
  input  logic       ack_i,
  output logic       idle_o,
  output logic       req_o,
  output logic       valid_o,
`ifdef AXI_RESPONDER_TIMEOUT_EN
  output logic       timeout_o,
`endif
  output logic [1:0] resp_o
);

  ch_state_t state_q, state_d;
  axi_resp_t resp_q, resp_d;
  logic      expire;

`ifdef AXI_RESPONDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Reloaded outside DEVICE; zero marks the last cycle a done is still accepted.
  assign expire = (state_q == CH_DEVICE) && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= CNT_LOAD;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == CH_DEVICE) ? cnt_q - 1'b1 : CNT_LOAD;
      timeout_q <= expire && !done_i;
    end
  end

  assign timeout_o = timeout_q;
`else
  // No watchdog in this build: a silent device stalls the channel.
  assign expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CH_IDLE;
      resp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    case (state_q)
      CH_IDLE: begin
        if (start_i) begin
          resp_d  = axi_resp_t'(dec_resp_i);
          state_d = (dec_resp_i == OKAY) ? CH_DEVICE : CH_RESP;
        end
      end
      CH_DEVICE: begin
        if (done_i) begin
          resp_d  = error_i ? SLVERR : OKAY;
          state_d = CH_RESP;
        end else if (expire) begin
          resp_d  = SLVERR;
          state_d = CH_RESP;
        end
      end
      CH_RESP: begin
        if (ack_i) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_comb begin
    idle_o  = (state_q == CH_IDLE);
    req_o   = (state_q == CH_DEVICE);
    valid_o = (state_q == CH_RESP);
    resp_o  = resp_q;
  end

endmodule

// File: rtl/axi_lite_mmio_responder.sv
// AXI4-Lite slave endpoint that turns register accesses into a level request/done device interface.
// Define AXI_RESPONDER_TIMEOUT_EN to add the device watchdog and the timeout_o port.
module axi_lite_mmio_responder
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter int          DEVICE_SPACE   = 4,
  parameter int          TIMEOUT_CYCLES = 256,
  localparam int         IDX_W          = (DEVICE_SPACE > 1) ? $clog2(DEVICE_SPACE) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      awaddr_i,
  input  logic             awvalid_i,
  output logic             awready_o,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [1:0]       bresp_o,
  output logic             bvalid_o,
  input  logic             bready_i,
  input  logic [31:0]      araddr_i,
  input  logic             arvalid_i,
  output logic             arready_o,
  output logic [31:0]      rdata_o,
  output logic [1:0]       rresp_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic             write_o,
  output logic [IDX_W-1:0] write_index_o,
  output logic [31:0]      write_data_o,
  output logic [3:0]       write_strobe_o,
  input  logic             write_done_i,
  input  logic             write_error_i,
  output logic             read_o,
  output logic [IDX_W-1:0] read_index_o,
  input  logic [31:0]      read_data_i,
  input  logic             read_done_i,
`ifdef AXI_RESPONDER_TIMEOUT_EN
  output logic             timeout_o,
`endif
  input  logic             read_error_i
);

  logic             ready_en_q;
  logic             aw_held_q, w_held_q;
  logic [IDX_W-1:0] widx_q, ridx_q;
  logic [31:0]      wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  axi_resp_t        w_dec_q;

  logic        w_idle, w_req, w_valid, r_idle, r_req, r_valid;
  logic [1:0]  w_resp, r_resp;
  logic        aw_hs, w_hs, ar_hs, w_start;
  logic [30:0] aw_word, ar_word;

  assign aw_word = {1'b0, awaddr_i[31:2]} - {1'b0, BASE_ADDRESS[31:2]};
  assign ar_word = {1'b0, araddr_i[31:2]} - {1'b0, BASE_ADDRESS[31:2]};

  // Readies stay low until the first clock after reset release.
  assign awready_o = ready_en_q && w_idle && !aw_held_q;
  assign wready_o  = ready_en_q && w_idle && !w_held_q;
  assign arready_o = ready_en_q && r_idle;

  assign aw_hs   = awvalid_i && awready_o;
  assign w_hs    = wvalid_i && wready_o;
  assign ar_hs   = arvalid_i && arready_o;
  assign w_start = w_idle && aw_held_q && w_held_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      widx_q     <= '0;
      w_dec_q    <= OKAY;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ridx_q     <= '0;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (w_start) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        widx_q    <= aw_word[IDX_W-1:0];
        w_dec_q   <= decode_addr(aw_word, awaddr_i[1:0], 32'(DEVICE_SPACE));
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata_i;
        wstrb_q  <= wstrb_i;
      end
      // Cleared on accept so decode errors and timeouts return zero data.
      if (ar_hs) begin
        ridx_q  <= ar_word[IDX_W-1:0];
        rdata_q <= '0;
      end else if (r_req && read_done_i) begin
        rdata_q <= read_data_i;
      end
    end
  end

`ifdef AXI_RESPONDER_TIMEOUT_EN
  logic w_timeout, r_timeout;
  assign timeout_o = w_timeout | r_timeout;
`endif

  axi_lite_channel_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_write_fsm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (w_start),
    .dec_resp_i(w_dec_q),
    .done_i    (write_done_i),
    .error_i   (write_error_i),
    .ack_i     (bready_i),
    .idle_o    (w_idle),
    .req_o     (w_req),
    .valid_o   (w_valid),
`ifdef AXI_RESPONDER_TIMEOUT_EN
    .timeout_o (w_timeout),
`endif
    .resp_o    (w_resp)
  );

  axi_lite_channel_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read_fsm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (ar_hs),
    .dec_resp_i(decode_addr(ar_word, araddr_i[1:0], 32'(DEVICE_SPACE))),
    .done_i    (read_done_i),
    .error_i   (read_error_i),
    .ack_i     (rready_i),
    .idle_o    (r_idle),
    .req_o     (r_req),
    .valid_o   (r_valid),
`ifdef AXI_RESPONDER_TIMEOUT_EN
    .timeout_o (r_timeout),
`endif
    .resp_o    (r_resp)
  );

  assign write_o        = w_req;
  assign write_index_o  = widx_q;
  assign write_data_o   = wdata_q;
  assign write_strobe_o = wstrb_q;
  assign bvalid_o       = w_valid;
  assign bresp_o        = w_resp;

  assign read_o       = r_req;
  assign read_index_o = ridx_q;
  assign rvalid_o     = r_valid;
  assign rresp_o      = r_resp;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_axi_lite_mmio_responder.sv
// Directed self-checking bench for axi_lite_mmio_responder (BASE 0x1000, 4 registers).
// Timeout scenarios run only when AXI_RESPONDER_TIMEOUT_EN is defined.
module tb_axi_lite_mmio_responder;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] awaddr_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [31:0] araddr_i = '0;
  logic        arvalid_i = 1'b0;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i = 1'b0;
  logic        write_o;
  logic [1:0]  write_index_o;
  logic [31:0] write_data_o;
  logic [3:0]  write_strobe_o;
  logic        write_done_i = 1'b0;
  logic        write_error_i = 1'b0;
  logic        read_o;
  logic [1:0]  read_index_o;
  logic [31:0] read_data_i = '0;
  logic        read_done_i = 1'b0;
  logic        read_error_i = 1'b0;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  // Device model knobs and observations.
  bit          rd_en = 1'b1, wr_en = 1'b1, rd_err = 1'b0, wr_err = 1'b0;
  int          rd_lat = 1, wr_lat = 1, rd_cnt = 0, wr_cnt = 0;
  int          rd_hi = 0, wr_hi = 0, tmo_cnt = 0;
  logic [31:0] rd_val = '0, wr_data_seen = '0;
  logic [1:0]  rd_idx_seen = '0, wr_idx_seen = '0;
  logic [3:0]  wr_strb_seen = '0;

  axi_lite_mmio_responder #(
    .BASE_ADDRESS  (32'h0000_1000),
    .DEVICE_SPACE  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .write_o(write_o), .write_index_o(write_index_o), .write_data_o(write_data_o),
    .write_strobe_o(write_strobe_o), .write_done_i(write_done_i), .write_error_i(write_error_i),
    .read_o(read_o), .read_index_o(read_index_o), .read_data_i(read_data_i),
    .read_done_i(read_done_i),
`ifdef AXI_RESPONDER_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .read_error_i(read_error_i)
  );

`ifndef AXI_RESPONDER_TIMEOUT_EN
  assign timeout_o = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  // Device model: observes request lines at the falling edge, answers after the set latency.
  initial begin
    forever begin
      @(negedge clk_i);
      if (timeout_o) tmo_cnt++;
      if (read_o) begin
        rd_hi++;
        rd_cnt++;
        if (rd_en && rd_cnt == rd_lat) begin
          read_done_i  = 1'b1;
          read_data_i  = rd_val;
          read_error_i = rd_err;
          rd_idx_seen  = read_index_o;
        end else begin
          read_done_i = 1'b0;
        end
      end else begin
        rd_cnt = 0;
        read_done_i = 1'b0;
        read_error_i = 1'b0;
        read_data_i = 32'hBAD0_BAD0;
      end
      if (write_o) begin
        wr_hi++;
        wr_cnt++;
        if (wr_en && wr_cnt == wr_lat) begin
          write_done_i  = 1'b1;
          write_error_i = wr_err;
          wr_idx_seen   = write_index_o;
          wr_data_seen  = write_data_o;
          wr_strb_seen  = write_strobe_o;
        end else begin
          write_done_i = 1'b0;
        end
      end else begin
        wr_cnt = 0;
        write_done_i = 1'b0;
        write_error_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b0; data = '0; resp = '0;
    araddr_i = addr; arvalid_i = 1'b1;
    n = 0;
    while (!arready_o && n < 50) begin tick(); n++; end
    tick();
    arvalid_i = 1'b0;
    if (n >= 50) return;
    n = 0;
    while (!rvalid_o && n < 100) begin tick(); n++; end
    if (!rvalid_o) return;
    data = rdata_o; resp = rresp_o;
    rready_i = 1'b1; tick(); rready_i = 1'b0;
    ok = 1'b1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit ok);
    int n;
    bit aw_d, w_d, awh, wh;
    ok = 1'b0; resp = '0; aw_d = 1'b0; w_d = 1'b0; n = 0;
    awaddr_i = addr; awvalid_i = 1'b1; wdata_i = data; wstrb_i = strb; wvalid_i = 1'b1;
    while (!(aw_d && w_d) && n < 50) begin
      awh = awvalid_i && awready_o;
      wh  = wvalid_i && wready_o;
      tick(); n++;
      if (awh) begin awvalid_i = 1'b0; aw_d = 1'b1; end
      if (wh)  begin wvalid_i = 1'b0; w_d = 1'b1; end
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    if (!(aw_d && w_d)) return;
    n = 0;
    while (!bvalid_o && n < 100) begin tick(); n++; end
    if (!bvalid_o) return;
    resp = bresp_o;
    bready_i = 1'b1; tick(); bready_i = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({awready_o, wready_o, bvalid_o, arready_o, rvalid_o, write_o, read_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {awready_o, wready_o, bvalid_o, arready_o, rvalid_o, write_o, read_o});
    end
    checks++;
    if ({bresp_o, rresp_o, rdata_o, write_data_o, write_strobe_o, write_index_o, read_index_o} !== '0) begin
      errors++; $display("FAIL reset_data: rdata %h wdata %h bresp %b rresp %b expected all 0", rdata_o, write_data_o, bresp_o, rresp_o);
    end
    rst_n_i = 1'b1;
    tick(); tick();
    checks++;
    if ({awready_o, wready_o, arready_o} !== 3'b111) begin
      errors++; $display("FAIL idle_ready: got %b expected 111", {awready_o, wready_o, arready_o});
    end
  endtask

  task automatic test_read_in_range();
    logic [31:0] d; logic [1:0] r; bit ok;
    rd_en = 1; rd_lat = 3; rd_val = 32'hDEAD_BEEF; rd_err = 0; rd_hi = 0;
    axi_read(32'h0000_1008, d, r, ok);
    checks++;
    if (!ok || d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      errors++; $display("FAIL read_okay: ok %0d data %h resp %b expected 1 deadbeef 00", ok, d, r);
    end
    checks++;
    if (rd_idx_seen !== 2'd2) begin
      errors++; $display("FAIL read_index: got %0d expected 2", rd_idx_seen);
    end
    checks++;
    if (rd_hi != 3) begin
      errors++; $display("FAIL read_req_len: got %0d expected 3", rd_hi);
    end
  endtask

  task automatic test_write_w_first();
    int n;
    logic [1:0] r;
    wr_en = 1; wr_lat = 2; wr_err = 0; wr_hi = 0; r = 2'bxx;
    wdata_i = 32'h1234_5678; wstrb_i = 4'b0011; wvalid_i = 1'b1;
    n = 0;
    while (!wready_o && n < 20) begin tick(); n++; end
    tick(); wvalid_i = 1'b0;
    tick(); tick();
    awaddr_i = 32'h0000_100C; awvalid_i = 1'b1;
    n = 0;
    while (!awready_o && n < 20) begin tick(); n++; end
    tick(); awvalid_i = 1'b0;
    n = 0;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    if (bvalid_o) begin
      r = bresp_o; bready_i = 1'b1; tick(); bready_i = 1'b0;
    end
    checks++;
    if (r !== 2'b00) begin
      errors++; $display("FAIL wfirst_bresp: got %b expected 00", r);
    end
    checks++;
    if ({wr_idx_seen, wr_data_seen, wr_strb_seen} !== {2'd3, 32'h1234_5678, 4'b0011}) begin
      errors++; $display("FAIL wfirst_dev: idx %0d data %h strb %b expected 3 12345678 0011", wr_idx_seen, wr_data_seen, wr_strb_seen);
    end
    checks++;
    if (wr_hi != 2) begin
      errors++; $display("FAIL wfirst_req_len: got %0d expected 2", wr_hi);
    end
  endtask

  task automatic test_decode_errors();
    logic [31:0] d; logic [1:0] r; bit ok;
    wr_hi = 0; rd_hi = 0;
    axi_write(32'h0000_1010, 32'hFFFF_FFFF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b11) begin
      errors++; $display("FAIL wr_out_of_window: ok %0d resp %b expected 11", ok, r);
    end
    axi_write(32'h0000_1001, 32'h0, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin
      errors++; $display("FAIL wr_misaligned: ok %0d resp %b expected 10", ok, r);
    end
    axi_read(32'h0000_0FFC, d, r, ok);
    checks++;
    if (!ok || r !== 2'b11 || d !== 32'h0) begin
      errors++; $display("FAIL rd_below_window: ok %0d resp %b data %h expected 11 0", ok, r, d);
    end
    axi_read(32'h0000_1002, d, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin
      errors++; $display("FAIL rd_misaligned: ok %0d resp %b expected 10", ok, r);
    end
    checks++;
    if (wr_hi != 0 || rd_hi != 0) begin
      errors++; $display("FAIL decode_no_access: write cycles %0d read cycles %0d expected 0 0", wr_hi, rd_hi);
    end
  endtask

  task automatic test_backpressure_error();
    int n;
    rd_en = 1; rd_lat = 1; rd_val = 32'hA5A5_0001; rd_err = 1;
    araddr_i = 32'h0000_1004; arvalid_i = 1'b1;
    n = 0;
    while (!arready_o && n < 20) begin tick(); n++; end
    tick();
    araddr_i = 32'h0000_1000;
    n = 0;
    while (!rvalid_o && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rvalid_o, rresp_o, arready_o, rdata_o} !== {1'b1, 2'b10, 1'b0, 32'hA5A5_0001}) begin
        errors++; $display("FAIL rd_hold c%0d: rvalid %b rresp %b arready %b rdata %h expected 1 10 0 a5a50001", i, rvalid_o, rresp_o, arready_o, rdata_o);
      end
      tick();
    end
    arvalid_i = 1'b0; rready_i = 1'b1; tick(); rready_i = 1'b0;
    checks++;
    if (rvalid_o !== 1'b0) begin
      errors++; $display("FAIL rd_release: rvalid %b expected 0", rvalid_o);
    end
    rd_err = 0;

    wr_en = 1; wr_lat = 1; wr_err = 1;
    awaddr_i = 32'h0000_1000; awvalid_i = 1'b1; wdata_i = 32'h0; wstrb_i = 4'hF; wvalid_i = 1'b1;
    n = 0;
    while (!(awready_o && wready_o) && n < 20) begin tick(); n++; end
    tick();
    wvalid_i = 1'b0; awaddr_i = 32'h0000_1004;
    n = 0;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bvalid_o, bresp_o, awready_o, wready_o} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
        errors++; $display("FAIL wr_hold c%0d: bvalid %b bresp %b awready %b wready %b expected 1 10 0 0", i, bvalid_o, bresp_o, awready_o, wready_o);
      end
      tick();
    end
    awvalid_i = 1'b0; bready_i = 1'b1; tick(); bready_i = 1'b0;
    checks++;
    if (bvalid_o !== 1'b0) begin
      errors++; $display("FAIL wr_release: bvalid %b expected 0", bvalid_o);
    end
    wr_err = 0;
  endtask

  task automatic test_concurrent();
    logic [31:0] d; logic [1:0] rr, br; bit rok, wok;
    rd_en = 1; rd_lat = 4; rd_val = 32'h1111_2222; rd_err = 0;
    wr_en = 1; wr_lat = 2; wr_err = 0;
    fork
      axi_read(32'h0000_1004, d, rr, rok);
      axi_write(32'h0000_1000, 32'hCAFE_F00D, 4'hF, br, wok);
    join
    checks++;
    if (!rok || d !== 32'h1111_2222 || rr !== 2'b00 || rd_idx_seen !== 2'd1) begin
      errors++; $display("FAIL conc_read: ok %0d data %h resp %b idx %0d expected 1 11112222 00 1", rok, d, rr, rd_idx_seen);
    end
    checks++;
    if (!wok || br !== 2'b00 || wr_idx_seen !== 2'd0 || wr_data_seen !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL conc_write: ok %0d resp %b idx %0d data %h expected 1 00 0 cafef00d", wok, br, wr_idx_seen, wr_data_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] d; logic [1:0] r; bit ok;
    wr_en = 0;
    awaddr_i = 32'h0000_1008; awvalid_i = 1'b1; wdata_i = 32'h55AA_55AA; wstrb_i = 4'hF; wvalid_i = 1'b1;
    n = 0;
    while (!(awready_o && wready_o) && n < 20) begin tick(); n++; end
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    n = 0;
    while (!write_o && n < 20) begin tick(); n++; end
    checks++;
    if (write_o !== 1'b1) begin
      errors++; $display("FAIL mid_write_req: write_o %b expected 1", write_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({awready_o, wready_o, bvalid_o, arready_o, rvalid_o, write_o, read_o, bresp_o, write_data_o, write_index_o} !== '0) begin
      errors++; $display("FAIL async_reset: write_o %b wdata %h awready %b bvalid %b expected all 0", write_o, write_data_o, awready_o, bvalid_o);
    end
    tick();
    rst_n_i = 1'b1; wr_en = 1; wr_lat = 1;
    tick(); tick(); tick();
    checks++;
    if ({bvalid_o, write_o} !== 2'b00) begin
      errors++; $display("FAIL no_aborted_resp: bvalid %b write_o %b expected 0 0", bvalid_o, write_o);
    end
    axi_write(32'h0000_1004, 32'h0000_BEEF, 4'b1100, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || {wr_idx_seen, wr_data_seen, wr_strb_seen} !== {2'd1, 32'h0000_BEEF, 4'b1100}) begin
      errors++; $display("FAIL post_reset_write: ok %0d resp %b idx %0d data %h strb %b expected 1 00 1 0000beef 1100", ok, r, wr_idx_seen, wr_data_seen, wr_strb_seen);
    end
    rd_lat = 1; rd_val = 32'h0000_0077;
    axi_read(32'h0000_100C, d, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || d !== 32'h0000_0077 || rd_idx_seen !== 2'd3) begin
      errors++; $display("FAIL post_reset_read: ok %0d resp %b data %h idx %0d expected 1 00 00000077 3", ok, r, d, rd_idx_seen);
    end
  endtask

`ifdef AXI_RESPONDER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d; logic [1:0] r; bit ok;
    rd_en = 0; rd_hi = 0; tmo_cnt = 0; rd_val = 32'h0F0F_0F0F;
    axi_read(32'h0000_1000, d, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || d !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: ok %0d resp %b data %h expected 1 10 0", ok, r, d);
    end
    checks++;
    if (rd_hi != 8 || tmo_cnt != 1) begin
      errors++; $display("FAIL timeout_len: req cycles %0d pulses %0d expected 8 1", rd_hi, tmo_cnt);
    end
    rd_en = 1; rd_lat = 8; rd_hi = 0; tmo_cnt = 0;
    axi_read(32'h0000_1000, d, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || d !== 32'h0F0F_0F0F || tmo_cnt != 0) begin
      errors++; $display("FAIL done_at_limit: ok %0d resp %b data %h pulses %0d expected 1 00 0f0f0f0f 0", ok, r, d, tmo_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_in_range();
    test_write_w_first();
    test_decode_errors();
    test_backpressure_error();
    test_concurrent();
    test_reset_mid();
`ifdef AXI_RESPONDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mmio_responder.md
Name: axi_lite_mmio_responder

Overview:
- Generic AXI4-Lite slave endpoint; terminates one slave port of the SoC AXI network and converts bursts-free AXI-Lite transactions into a simple register-access strobe interface for a peripheral (UART, timer, GPIO, SPI, PRNG, ...).
- Performs offset decode against the device's MMIO window and generates OKAY/SLVERR/DECERR responses.
- Write and read channels are independent and may be in flight simultaneously.

Parameters:
- BASE_ADDRESS, 32'h0, byte address of the device window, taken from the SoC MMIO map.
- DEVICE_SPACE, 4, number of 32-bit registers in the window; must be ≥1.
- TIMEOUT_CYCLES, 256, device-completion watchdog limit; used only with AXI_RESPONDER_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- awaddr_i  in  32  write address
- awvalid_i / awready_o  in/out  1  AW handshake
- wdata_i  in  32  write data
- wstrb_i  in  4  write byte strobes
- wvalid_i / wready_o  in/out  1  W handshake
- bresp_o  out  2  write response
- bvalid_o / bready_i  out/in  1  B handshake
- araddr_i  in  32  read address
- arvalid_i / arready_o  in/out  1  AR handshake
- rdata_o  out  32  read data
- rresp_o  out  2  read response
- rvalid_o / rready_i  out/in  1  R handshake
- write_o  out  1  device write request, level, held until write_done_i
- write_index_o  out  $clog2(DEVICE_SPACE) (min 1)  register index
- write_data_o / write_strobe_o  out  32 / 4  data and byte enables
- write_done_i / write_error_i  in  1  completion and error flag (sampled with done)
- read_o  out  1  device read request, level, held until read_done_i
- read_index_o  out  $clog2(DEVICE_SPACE) (min 1)  register index
- read_data_i  in  32  read data, valid with read_done_i
- read_done_i / read_error_i  in  1  completion and error flag

Behaviour:
- Clock/reset: single clock clk_i; asynchronous active-low reset rst_n_i.
- Reset values: all valid, ready and request outputs are 0; all data, index and resp outputs are 0; both FSMs are in IDLE.
- Decode:
  - offset = addr − BASE_ADDRESS; index = offset[31:2].
  - addr < BASE_ADDRESS or index ≥ DEVICE_SPACE → DECERR (2'b11).
  - addr[1:0] ≠ 0 → SLVERR (2'b10).
  - Otherwise the device is accessed; device error → SLVERR; success → OKAY (2'b00).
  - DECERR takes priority over SLVERR.
- Write FSM:
  - W_IDLE: awready_o = 1 until AW is captured; wready_o = 1 until W is captured. AW and W are accepted in any order or in the same cycle and latched.
  - Once both are held: decode error → W_RESP with no device access (write_o never asserts); else → W_DEVICE.
  - W_DEVICE: write_o = 1 with stable index, data and strobe. On write_done_i → W_RESP, with write_o deasserting in that same transition. Latency is one cycle minimum from the second handshake to write_o.
  - W_RESP: bvalid_o = 1 and bresp_o stable until bready_i; then → W_IDLE.
  - No new AW/W is accepted outside W_IDLE (single outstanding write).
- Read FSM:
  - R_IDLE: arready_o = 1. On the AR handshake, latch the address; decode error → R_RESP with rdata_o = 0; else → R_DEVICE.
  - R_DEVICE: read_o = 1 until read_done_i. On done, register read_data_i into rdata_o, set the resp, → R_RESP.
  - R_RESP: rvalid_o held with stable rdata_o/rresp_o until rready_i; then → R_IDLE.
  - Single outstanding read.
- Device-side concurrency: write_o and read_o may be high together; the device is responsible for arbitration.
- Zero-wait completion: done asserted in the first request cycle is legal.
- Done outside a request: write_done_i or read_done_i asserted while the matching request is low is ignored.
- Reset mid-operation: all state is discarded immediately; no response is issued for the aborted transaction.

Optional Feature:
- Macro: AXI_RESPONDER_TIMEOUT_EN.
- When defined:
  - Per-channel counters of width $clog2(TIMEOUT_CYCLES+1) run while in W_DEVICE or R_DEVICE.
  - On reaching TIMEOUT_CYCLES without done: drop the request, respond SLVERR (read data 0), and pulse timeout_o (extra output port, 1 bit, 1-cycle pulse).
  - A done arriving in the same cycle as the timeout wins (OKAY/device resp).
- When not defined: no counter and no timeout_o port; a silent device stalls its channel indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - axi_resp_t enum: OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
  - write/read FSM state enums.
  - ADDR_WIDTH = 32 and DATA_WIDTH = 32 constants.
- One natural sub-module, axi_lite_channel_fsm, implements the request/response handshake shared by the write and read channels. It is instantiated twice.

Test Plan:
- Read, in range: BASE = 32'h1000, DEVICE_SPACE = 4; read 32'h1008, device returns 32'hDEADBEEF after 3 cycles → read_index_o = 2, rdata_o = 32'hDEADBEEF, rresp_o = OKAY; read_o high exactly until done.
- W before AW: W (32'h12345678, wstrb 4'b0011) two cycles before AW 32'h100C → write_o with index 3, data and strobe exact, bresp OKAY.
- Out-of-window and misaligned accesses:
  - Write 32'h1010 → DECERR; read 32'h0FFC → DECERR with rdata 0; device request lines stay 0.
  - Read 32'h1002 → SLVERR.
- Backpressure and error: bready_i/rready_i held low 10 cycles → bvalid/rvalid and resp stable, no new AW/AR accepted; device read_error_i = 1 → SLVERR.
- Concurrency and reset: simultaneous read of index 1 and write of index 0 complete independently. Then assert rst_n_i low during W_DEVICE → all outputs 0 asynchronously, and the next transaction after reset completes normally.
- Timeout (with AXI_RESPONDER_TIMEOUT_EN, TIMEOUT_CYCLES = 8): device never completes → SLVERR after 8 cycles in R_DEVICE, timeout_o pulses once. Done arriving on cycle 8 → OKAY.
